// File: rtl/div_issue_ctrl.sv
// Issue controller for a multi-cycle divider: request FIFO, start/complete handshake,
// divide-by-zero bypass and a held response towards downstream.
module div_issue_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             div_start,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quot,
  output logic [WIDTH-1:0] rsp_rem,
  output logic             rsp_dz,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mem_x_q [DEPTH];
  logic [WIDTH-1:0] mem_y_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             dv_prev_q;
  logic             div_start_q, rsp_valid_q, rsp_dz_q;
  logic [WIDTH-1:0] div_x_q, div_y_q, rsp_quot_q, rsp_rem_q;
  logic [WIDTH-1:0] head_x, head_y;
  logic             full, push, pop, done;

  assign full   = (count_q == FULL_CNT);
  assign push   = rst && req_valid && !full;
  assign pop    = (state_q == IDLE) && (count_q != '0);
  // Completion is the rising edge only, so a level left high from the last job is ignored.
  assign done   = div_valid && !dv_prev_q;
  assign head_x = mem_x_q[rd_ptr_q];
  assign head_y = mem_y_q[rd_ptr_q];

  assign req_ready = !rst || !full;
  assign busy      = rst && ((state_q != IDLE) || (count_q != '0));
  assign div_start = div_start_q;
  assign div_x     = div_x_q;
  assign div_y     = div_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_quot  = rsp_quot_q;
  assign rsp_rem   = rsp_rem_q;
  assign rsp_dz    = rsp_dz_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x_q[wr_ptr_q] <= req_x;
      mem_y_q[wr_ptr_q] <= req_y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      dv_prev_q   <= 1'b0;
      div_start_q <= 1'b0;
      div_x_q     <= '0;
      div_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_dz_q    <= 1'b0;
    end else begin
      dv_prev_q <= div_valid;
      case (state_q)
        IDLE: begin
          if (pop) begin
            div_x_q <= head_x;
            div_y_q <= head_y;
            if (head_y == '0) begin
              state_q     <= HOLD;
              rsp_quot_q  <= '1;
              rsp_rem_q   <= head_x;
              rsp_dz_q    <= 1'b1;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q     <= ISSUE;
              div_start_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          div_start_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (done) begin
            rsp_quot_q  <= div_quot;
            rsp_rem_q   <= div_rem;
            rsp_dz_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider that answers 5 cycles
// after each start pulse.
module tb_div_issue_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_x = '0, req_y = '0;
  logic         div_start;
  logic [W-1:0] div_x, div_y;
  logic         div_valid = 1'b0;
  logic [W-1:0] div_quot = '0, div_rem = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_quot, rsp_rem;
  logic         rsp_dz;
  logic         busy;

  int total = 0;
  int bad = 0;
  int starts = 0;
  int mcnt = 0;
  logic [W-1:0] mx = '0, my = '0;
  logic hold_mode = 1'b0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .div_start(div_start), .div_x(div_x), .div_y(div_y),
    .div_valid(div_valid), .div_quot(div_quot), .div_rem(div_rem),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_dz(rsp_dz), .busy(busy)
  );

  // Divider model: ignores controller reset; in hold_mode its valid level stays high
  // between jobs and only dips for one cycle just before the new answer.
  always @(posedge clk) begin
    if (div_start) begin
      starts <= starts + 1;
      mx     <= div_x;
      my     <= div_y;
      mcnt   <= 5;
      if (!hold_mode) div_valid <= 1'b0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 2 && hold_mode) div_valid <= 1'b0;
      if (mcnt == 1) begin
        div_valid <= 1'b1;
        div_quot  <= (my == '0) ? '1 : mx / my;
        div_rem   <= (my == '0) ? mx : mx % my;
      end
    end else if (!hold_mode) begin
      div_valid <= 1'b0;
    end
  end

  typedef struct {
    logic [W-1:0] x, y, q, r;
    logic         dz;
  } vec_t;
  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(input string nm, output int n);
    n = 0;
    while (!rsp_valid && n < 60) begin
      step();
      n++;
    end
    if (!rsp_valid) chk({nm, " timeout"}, 0, 1);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int s0, n;
    s0 = starts;
    req_x = v.x; req_y = v.y; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk({nm, " busy"}, busy, 1);
    if (v.dz) begin
      chk({nm, " rsp_valid after pop"}, rsp_valid, 1);
      chk({nm, " no start"}, div_start, 0);
    end else begin
      chk({nm, " start"}, div_start, 1);
      chk({nm, " div_x"}, div_x, v.x);
      chk({nm, " div_y"}, div_y, v.y);
    end
    wait_rsp(nm, n);
    if (!v.dz) chk({nm, " latency"}, n, 7);
    chk({nm, " quot"}, rsp_quot, v.q);
    chk({nm, " rem"}, rsp_rem, v.r);
    chk({nm, " dz"}, rsp_dz, v.dz);
    step();
    chk({nm, " rsp released"}, rsp_valid, 0);
    chk({nm, " start count"}, starts - s0, v.dz ? 0 : 1);
  endtask

  task automatic collect(input string nm, input int q, input int r, input int dz);
    int n;
    wait_rsp(nm, n);
    chk({nm, " quot"}, rsp_quot, q);
    chk({nm, " rem"}, rsp_rem, r);
    chk({nm, " dz"}, rsp_dz, dz);
    step();
  endtask

  task automatic push(input int x, input int y);
    req_x = W'(x); req_y = W'(y); req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " div_start"}, div_start, 0);
    chk({nm, " rsp_valid"}, rsp_valid, 0);
    chk({nm, " rsp_dz"}, rsp_dz, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " rsp_quot"}, rsp_quot, 0);
    chk({nm, " rsp_rem"}, rsp_rem, 0);
    chk({nm, " div_x"}, div_x, 0);
    chk({nm, " div_y"}, div_y, 0);
    chk({nm, " req_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, hits;
    tbl[0] = '{x: 4'd15, y: 4'd8,  q: 4'd1,  r: 4'd7, dz: 1'b0};
    tbl[1] = '{x: 4'd10, y: 4'd2,  q: 4'd5,  r: 4'd0, dz: 1'b0};
    tbl[2] = '{x: 4'd9,  y: 4'd0,  q: 4'd15, r: 4'd9, dz: 1'b1};
    tbl[3] = '{x: 4'd7,  y: 4'd3,  q: 4'd2,  r: 4'd1, dz: 1'b0};
    tbl[4] = '{x: 4'd0,  y: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
    tbl[5] = '{x: 4'd15, y: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
    tbl[6] = '{x: 4'd3,  y: 4'd15, q: 4'd0,  r: 4'd3, dz: 1'b0};
    tbl[7] = '{x: 4'd0,  y: 4'd0,  q: 4'd15, r: 4'd0, dz: 1'b1};

    // Reset, with a request offered while reset is held.
    rst = 1'b0;
    step();
    req_x = 4'd5; req_y = 4'd1; req_valid = 1'b1;
    step();
    check_reset_outputs("reset");
    req_valid = 1'b0;
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid || div_start || busy) hits++;
    end
    chk("push during reset ignored", hits, 0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back requests keep order.
    s0 = starts;
    push(15, 8);
    push(10, 2);
    collect("b2b first", 1, 7, 0);
    collect("b2b second", 5, 0, 0);
    chk("b2b start count", starts - s0, 2);

    // Divider valid left high between operations.
    hold_mode = 1'b1;
    run_vec("stale first", tbl[0]);
    run_vec("stale second", tbl[1]);
    hold_mode = 1'b0;
    repeat (3) step();

    // Backpressure: fill the FIFO behind a held response.
    rsp_ready = 1'b0;
    push(15, 8);
    push(10, 2);
    push(7, 3);
    push(9, 0);
    chk("5th push ready", req_ready, 1);
    push(14, 4);
    chk("full req_ready", req_ready, 0);
    push(13, 1);
    collect("bp first", 1, 7, 0);
    chk("bp still valid", rsp_valid, 1);
    repeat (4) step();
    chk("bp hold valid", rsp_valid, 1);
    chk("bp hold quot", rsp_quot, 1);
    chk("bp hold rem", rsp_rem, 7);
    chk("bp hold dz", rsp_dz, 0);
    chk("bp hold full", req_ready, 0);
    rsp_ready = 1'b1;
    step();
    collect("bp b", 5, 0, 0);
    collect("bp c", 2, 1, 0);
    collect("bp d", 15, 9, 1);
    collect("bp e", 3, 2, 0);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid) hits++;
    end
    chk("bp dropped 6th", hits, 0);
    chk("bp idle busy", busy, 0);

    // Reset in WAIT with two queued; the late completion must be ignored.
    push(15, 8);
    push(10, 2);
    push(7, 3);
    step();
    chk("pre-reset busy", busy, 1);
    rst = 1'b0;
    step();
    check_reset_outputs("mid reset");
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid || div_start || busy) hits++;
    end
    chk("late completion ignored", hits, 0);
    run_vec("after reset", '{x: 4'd6, y: 4'd3, q: 4'd2, r: 4'd0, dz: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits.
REQ-002 Parameter: DEPTH, 4, request FIFO entries; power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low.
REQ-005 Port: req_valid  input  1  upstream request present.
REQ-006 Port: req_ready  output  1  FIFO can accept; equals not-full.
REQ-007 Port: req_x  input  WIDTH  dividend.
REQ-008 Port: req_y  input  WIDTH  divisor.
REQ-009 Port: div_start  output  1  one-cycle start pulse to the divider.
REQ-010 Port: div_x  output  WIDTH  dividend to the divider.
REQ-011 Port: div_y  output  WIDTH  divisor to the divider.
REQ-012 Port: div_valid  input  1  divider completion level.
REQ-013 Port: div_quot  input  WIDTH  divider quotient.
REQ-014 Port: div_rem  input  WIDTH  divider remainder.
REQ-015 Port: rsp_valid  output  1  result available downstream.
REQ-016 Port: rsp_ready  input  1  downstream accepts the result.
REQ-017 Port: rsp_quot  output  WIDTH  quotient.
REQ-018 Port: rsp_rem  output  WIDTH  remainder.
REQ-019 Port: rsp_dz  output  1  divide-by-zero flag.
REQ-020 Port: busy  output  1  high when state is not IDLE or the FIFO is non-empty.

Function
REQ-021 A push SHALL occur on any edge where req_valid and req_ready are both high; the FIFO SHALL preserve order.
REQ-022 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-023 When full, req_ready SHALL be low and the request SHALL NOT be written.
REQ-024 The state machine SHALL have four states: IDLE, ISSUE, WAIT and HOLD.
REQ-025 In IDLE with the FIFO non-empty, the next edge SHALL pop the head into the operand registers.
REQ-026 After that pop, the FSM SHALL go to ISSUE if the divisor is non-zero.
REQ-027 After that pop, the FSM SHALL go to HOLD with rsp_quot all ones, rsp_rem equal to the dividend and rsp_dz=1 if the divisor is zero.
REQ-028 When rsp_dz=1, div_start SHALL NOT pulse for that request.
REQ-029 div_start SHALL be high in ISSUE only, for exactly one cycle, and the FSM SHALL then go to WAIT.
REQ-030 div_x and div_y SHALL hold the operand registers and remain stable from ISSUE through WAIT.
REQ-031 In WAIT, completion SHALL be detected as div_valid high with its registered previous value low (rising edge).
REQ-032 A div_valid level left high from the previous operation SHALL NOT be taken as completion.
REQ-033 On completion, div_quot and div_rem SHALL be captured into rsp_quot and rsp_rem, rsp_dz SHALL be 0, and the FSM SHALL go to HOLD.
REQ-034 rsp_valid SHALL be high exactly in HOLD.
REQ-035 rsp_quot, rsp_rem and rsp_dz SHALL remain stable while rsp_valid is high and rsp_ready is low.
REQ-036 In HOLD with rsp_ready high, the FSM SHALL go to IDLE, with at most one result outstanding.
REQ-037 Latency, non-zero divisor, rsp_ready held high: pop at edge E, div_start high in cycle E..E+1.
REQ-038 With the same conditions, rsp_valid SHALL rise one cycle after the div_valid rising edge.
REQ-039 A divide-by-zero request SHALL raise rsp_valid one cycle after its pop.
REQ-040 Pushes SHALL continue in every state while the FIFO is not full.

Reset
REQ-041 On any edge with rst=0, the FSM SHALL go to IDLE and the FIFO pointers and count SHALL clear.
REQ-042 While reset is applied, div_start, rsp_valid, rsp_dz and busy SHALL be 0.
REQ-043 While reset is applied, rsp_quot, rsp_rem, div_x, div_y and the previous-div_valid register SHALL be 0.
REQ-044 While reset is applied, req_ready SHALL be 1.
REQ-045 Reset applied in ISSUE, WAIT or HOLD SHALL discard the in-flight request and all queued requests.
REQ-046 A divider completion arriving after reset SHALL be ignored.
REQ-047 Reset SHALL take priority over simultaneous push, pop or completion.

Verification
REQ-048 Push X=15, Y=8; the divider model asserts valid 5 cycles after start -> one div_start pulse with div_x=15, div_y=8; rsp_quot=1, rsp_rem=7, rsp_dz=0.
REQ-049 Push 15/8 then 10/2 back-to-back -> responses in order: (1,7) then (5,0); two div_start pulses.
REQ-050 Push X=9, Y=0 -> no div_start; rsp_quot=15, rsp_rem=9, rsp_dz=1 one cycle after the pop.
REQ-051 Hold rsp_ready=0 and push 6 requests -> 1 popped to the divider and 4 queued; req_ready low at the 6th push, which is not written; rsp outputs stable until rsp_ready=1.
REQ-052 Keep div_valid high between operations -> the second request waits for a fresh rising edge and does not complete early.
REQ-053 Apply rst=0 for one cycle during WAIT with 2 queued -> all outputs return to reset values, the late div_valid is ignored, and busy=0.
